// File: rtl/move_link_pkg.sv
// Shared definitions for the inter-board move link: receiver states, default
// framing/oversampling constants and the bit-voting helper.
package move_link_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int DEF_PKT_LEN      = 8;
  localparam int DEF_SAMP_PER_BIT = 16;
  localparam int DEF_CLK_PER_SAMP = 423;
  // One bit period in clk_in cycles; the transmitter uses the same figure.
  localparam int BIT_PERIOD_CLK   = DEF_SAMP_PER_BIT * DEF_CLK_PER_SAMP;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/move_uart_rx_sync_2ff.sv
// Two-stage synchronizer for a single asynchronous level, with a selectable
// reset value so an idle-high line does not look like a start edge out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two flops in series to let metastability on the first one settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/move_uart_rx.sv
// Oversampling 8N1 receiver for the move link: majority-votes each bit around
// mid-bit, checks the stop bit and reports good bytes or framing errors.
module move_uart_rx
  import move_link_pkg::*;
#(
  parameter int CLK_HZ       = 65_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int SAMP_PER_BIT = DEF_SAMP_PER_BIT,
  parameter int CLK_PER_SAMP = DEF_CLK_PER_SAMP,
  parameter int PKT_LEN      = DEF_PKT_LEN
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rx,
  output logic [PKT_LEN-1:0] data_out,
  output logic               ready,
  output logic               frame_err,
  output logic               busy
);

  localparam int MID = SAMP_PER_BIT / 2;
  localparam int TW  = $clog2(CLK_PER_SAMP);
  localparam int SW  = $clog2(SAMP_PER_BIT);
  localparam int BW  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  if ((SAMP_PER_BIT < 4) || ((SAMP_PER_BIT % 2) != 0) || (CLK_PER_SAMP < 2) ||
      (CLK_HZ < BAUD_RATE)) begin : g_bad_cfg
    $error("move_uart_rx: unsupported oversampling configuration");
  end

  logic               rx_s;
  logic [TW-1:0]      tick_cnt_r;
  logic [SW-1:0]      samp_cnt_r;
  logic [1:0]         vote_r;
  rx_state_t          state_r;
  logic [PKT_LEN-1:0] shift_r;
  logic [BW-1:0]      bit_idx_r;
  logic [PKT_LEN-1:0] data_r;
  logic               ready_r;
  logic               frame_err_r;
  logic               busy_r;

  logic tick_s;
  logic start_s;
  logic take_s;
  logic vote_en_s;
  logic vote_s;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk_in),
    .rst_n(rst_in),
    .d    (rx),
    .q    (rx_s)
  );

  assign tick_s    = (tick_cnt_r == TW'(CLK_PER_SAMP - 1));
  assign start_s   = (state_r == IDLE) && !rx_s;
  assign take_s    = tick_s && ((samp_cnt_r == SW'(MID - 1)) || (samp_cnt_r == SW'(MID)));
  assign vote_en_s = tick_s && (samp_cnt_r == SW'(MID + 1));
  // Samples MID-1 and MID are held in vote_r; MID+1 is the live synced value.
  assign vote_s    = maj3(vote_r[1], vote_r[0], rx_s);

  // Sample-tick timebase, re-phased to every detected start edge.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tick_cnt_r <= {TW{1'b0}};
      samp_cnt_r <= {SW{1'b0}};
      vote_r     <= 2'b00;
    end else if (start_s) begin
      tick_cnt_r <= {TW{1'b0}};
      // The detect edge itself stands in for sample 0 of the start bit.
      samp_cnt_r <= SW'(1);
    end else if (tick_s) begin
      tick_cnt_r <= {TW{1'b0}};
      samp_cnt_r <= (samp_cnt_r == SW'(SAMP_PER_BIT - 1)) ? {SW{1'b0}} : samp_cnt_r + SW'(1);
      if (take_s) begin
        vote_r <= {vote_r[0], rx_s};
      end
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // Frame state machine with registered data, pulse and busy outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r     <= IDLE;
      shift_r     <= {PKT_LEN{1'b0}};
      bit_idx_r   <= {BW{1'b0}};
      data_r      <= {PKT_LEN{1'b0}};
      ready_r     <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      ready_r     <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_r <= START;
            busy_r  <= 1'b1;
          end
        end
        START: begin
          if (vote_en_s) begin
            if (vote_s) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r   <= DATA;
              bit_idx_r <= {BW{1'b0}};
            end
          end
        end
        DATA: begin
          if (vote_en_s) begin
            shift_r   <= {vote_s, shift_r[PKT_LEN-1:1]};
            bit_idx_r <= bit_idx_r + BW'(1);
            if (bit_idx_r == BW'(PKT_LEN - 1)) begin
              state_r <= STOP;
            end
          end
        end
        STOP: begin
          // Decide at mid stop bit so a back-to-back start edge is not missed.
          if (vote_en_s) begin
            if (vote_s) begin
              data_r  <= shift_r;
              ready_r <= 1'b1;
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else begin
              frame_err_r <= 1'b1;
              state_r     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = data_r;
  assign ready     = ready_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule
